// File: rtl/alarm_ctrl_pkg.sv
// Shared types and BCD field positions for the alarm mode controller.
package alarm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SET_ALARM = 2'd1,
    RINGING   = 2'd2,
    SNOOZE    = 2'd3
  } state_t;

  localparam int HH_HI = 23;
  localparam int HH_LO = 16;
  localparam int MM_HI = 15;
  localparam int MM_LO = 8;
  localparam int SS_HI = 7;
  localparam int SS_LO = 0;

endpackage

// File: rtl/alarm_ctrl_fsm_rise_detect.sv
// Registered rising-edge detector; the history flop's reset value decides
// whether a level already high at reset release counts as an edge.
module rise_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetN,
  input  logic din,
  output logic rise
);

  logic din_p0;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      din_p0 <= RESET_VAL;
      rise   <= 1'b0;
    end else begin
      din_p0 <= din;
      rise   <= din & ~din_p0;
    end
  end

endmodule

// File: rtl/alarm_ctrl_fsm.sv
// Mode/alarm controller: routes button pulses to time or alarm counters and
// sequences ringing, snooze and dismiss around a once-per-minute match edge.
module alarm_ctrl_fsm
  import alarm_ctrl_pkg::*;
#(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300,
  parameter int MAX_SNOOZES    = 3,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             clk_1s,
  input  logic             add_hour_pulse,
  input  logic             add_minute_pulse,
  input  logic             set_alarm_sw,
  input  logic             alarm_en,
  input  logic [23:0]      current_time,
  input  logic [23:0]      alm_time,
  output logic             clk_add_hour,
  output logic             clk_add_minute,
  output logic             alm_add_hour,
  output logic             alm_add_minute,
  output logic             show_alarm,
  output logic             ringing,
  output logic             snoozing,
  output logic [CNT_W-1:0] snooze_left,
  output logic [1:0]       state_dbg
);

  localparam int               SNZ_W       = $clog2(MAX_SNOOZES + 2);
  localparam logic [CNT_W-1:0] RING_LOAD   = CNT_W'(RING_TIMEOUT_S);
  localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_S);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [SNZ_W-1:0] SNZ_MAX     = SNZ_W'(MAX_SNOOZES);

  state_t           state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [SNZ_W-1:0] snz, nxt_snz;
  logic             match, tick, match_rise;
  logic             alm_ss_unused;

  // Alarm seconds never take part in the compare; only HH:MM and SS==00 do.
  assign alm_ss_unused = ^alm_time[SS_HI:SS_LO];
  assign match = alarm_en
              && (current_time[HH_HI:HH_LO] == alm_time[HH_HI:HH_LO])
              && (current_time[MM_HI:MM_LO] == alm_time[MM_HI:MM_LO])
              && (current_time[SS_HI:SS_LO] == 8'h00);

  rise_detect #(.RESET_VAL(1'b0)) u_tick_rise (
    .clk    (clk),
    .resetN (resetN),
    .din    (clk_1s),
    .rise   (tick)
  );

  rise_detect #(.RESET_VAL(1'b1)) u_match_rise (
    .clk    (clk),
    .resetN (resetN),
    .din    (match),
    .rise   (match_rise)
  );

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_snz   = snz;
    case (state)
      IDLE: begin
        if (set_alarm_sw) begin
          nxt_state = SET_ALARM;
        end else if (match_rise) begin
          nxt_state = RINGING;
          nxt_cnt   = RING_LOAD;
          nxt_snz   = '0;
        end
      end
      SET_ALARM: begin
        if (!set_alarm_sw) nxt_state = IDLE;
      end
      RINGING: begin
        if (set_alarm_sw) begin
          nxt_state = SET_ALARM;
        end else if (add_hour_pulse) begin
          nxt_state = IDLE;
        end else if (add_minute_pulse) begin
          if (snz == SNZ_MAX) begin
            nxt_state = IDLE;
          end else begin
            nxt_state = SNOOZE;
            nxt_cnt   = SNOOZE_LOAD;
            nxt_snz   = snz + 1'b1;
          end
        end else if (tick) begin
          if (cnt == CNT_ONE)     nxt_state = IDLE;
          else if (cnt > CNT_ONE) nxt_cnt   = cnt - 1'b1;
        end
      end
      SNOOZE: begin
        if (set_alarm_sw) begin
          nxt_state = SET_ALARM;
        end else if (add_hour_pulse) begin
          nxt_state = IDLE;
        end else if (tick) begin
          if (cnt == CNT_ONE) begin
            nxt_state = RINGING;
            nxt_cnt   = RING_LOAD;
          end else if (cnt > CNT_ONE) begin
            nxt_cnt = cnt - 1'b1;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
    // Any exit from the ring/snooze cycle ends the alarm event entirely.
    if (nxt_state == IDLE || nxt_state == SET_ALARM) begin
      nxt_cnt = '0;
      nxt_snz = '0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state          <= IDLE;
      cnt            <= '0;
      snz            <= '0;
      clk_add_hour   <= 1'b0;
      clk_add_minute <= 1'b0;
      alm_add_hour   <= 1'b0;
      alm_add_minute <= 1'b0;
      show_alarm     <= 1'b0;
      ringing        <= 1'b0;
      snoozing       <= 1'b0;
      snooze_left    <= '0;
    end else begin
      state          <= nxt_state;
      cnt            <= nxt_cnt;
      snz            <= nxt_snz;
      clk_add_hour   <= (state == IDLE) && add_hour_pulse;
      clk_add_minute <= (state == IDLE) && add_minute_pulse;
      alm_add_hour   <= (state == SET_ALARM) && add_hour_pulse;
      alm_add_minute <= (state == SET_ALARM) && add_minute_pulse;
      show_alarm     <= (nxt_state == SET_ALARM);
      ringing        <= (nxt_state == RINGING);
      snoozing       <= (nxt_state == SNOOZE);
      snooze_left    <= (nxt_state == SNOOZE) ? nxt_cnt : '0;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_alarm_ctrl_fsm.sv
// Randomized bench for alarm_ctrl_fsm against a seconds-remaining reference model.
module tb_alarm_ctrl_fsm;

  localparam int RING = 4;
  localparam int SNZ  = 3;
  localparam int MAXS = 2;
  localparam int CW   = 16;

  logic          clk = 1'b0;
  logic          resetN;
  logic          clk_1s;
  logic          add_hour_pulse;
  logic          add_minute_pulse;
  logic          set_alarm_sw;
  logic          alarm_en;
  logic [23:0]   current_time;
  logic [23:0]   alm_time;
  logic          clk_add_hour;
  logic          clk_add_minute;
  logic          alm_add_hour;
  logic          alm_add_minute;
  logic          show_alarm;
  logic          ringing;
  logic          snoozing;
  logic [CW-1:0] snooze_left;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;

  // Reference model: the alarm is described by how many seconds of ringing
  // or snoozing remain, plus whether the user is editing the alarm.
  bit editing;
  int ring_left, snz_left, used;
  bit c1_prev, tick_q, m_prev, mrise_q;
  bit e_ch, e_cm, e_ah, e_am;

  always #5 clk = ~clk;

  alarm_ctrl_fsm #(
    .RING_TIMEOUT_S (RING),
    .SNOOZE_S       (SNZ),
    .MAX_SNOOZES    (MAXS),
    .CNT_W          (CW)
  ) dut (
    .clk              (clk),
    .resetN           (resetN),
    .clk_1s           (clk_1s),
    .add_hour_pulse   (add_hour_pulse),
    .add_minute_pulse (add_minute_pulse),
    .set_alarm_sw     (set_alarm_sw),
    .alarm_en         (alarm_en),
    .current_time     (current_time),
    .alm_time         (alm_time),
    .clk_add_hour     (clk_add_hour),
    .clk_add_minute   (clk_add_minute),
    .alm_add_hour     (alm_add_hour),
    .alm_add_minute   (alm_add_minute),
    .show_alarm       (show_alarm),
    .ringing          (ringing),
    .snoozing         (snoozing),
    .snooze_left      (snooze_left),
    .state_dbg        (state_dbg)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mode_code();
    if (editing)       return 1;
    if (ring_left > 0) return 2;
    if (snz_left > 0)  return 3;
    return 0;
  endfunction

  task automatic model_reset();
    editing   = 1'b0;
    ring_left = 0;
    snz_left  = 0;
    used      = 0;
    c1_prev   = 1'b0;
    tick_q    = 1'b0;
    m_prev    = 1'b1;
    mrise_q   = 1'b0;
    e_ch = 1'b0; e_cm = 1'b0; e_ah = 1'b0; e_am = 1'b0;
  endtask

  task automatic end_event();
    ring_left = 0;
    snz_left  = 0;
    used      = 0;
  endtask

  task automatic model_step();
    bit tick_now, mrise_now, m;
    int mode;
    tick_now  = tick_q;
    mrise_now = mrise_q;
    tick_q    = clk_1s && !c1_prev;
    c1_prev   = clk_1s;
    m = alarm_en && (current_time[23:8] == alm_time[23:8]) && (current_time[7:0] == 8'h00);
    mrise_q = m && !m_prev;
    m_prev  = m;
    mode = mode_code();
    e_ch = (mode == 0) && add_hour_pulse;
    e_cm = (mode == 0) && add_minute_pulse;
    e_ah = (mode == 1) && add_hour_pulse;
    e_am = (mode == 1) && add_minute_pulse;
    if (editing) begin
      if (!set_alarm_sw) editing = 1'b0;
    end else if (ring_left > 0) begin
      if (set_alarm_sw) begin
        editing = 1'b1;
        end_event();
      end else if (add_hour_pulse) begin
        end_event();
      end else if (add_minute_pulse) begin
        if (used == MAXS) end_event();
        else begin
          ring_left = 0;
          snz_left  = SNZ;
          used++;
        end
      end else if (tick_now) begin
        ring_left--;
        if (ring_left == 0) end_event();
      end
    end else if (snz_left > 0) begin
      if (set_alarm_sw) begin
        editing = 1'b1;
        end_event();
      end else if (add_hour_pulse) begin
        end_event();
      end else if (tick_now) begin
        snz_left--;
        if (snz_left == 0) ring_left = RING;
      end
    end else begin
      if (set_alarm_sw) editing = 1'b1;
      else if (mrise_now) begin
        ring_left = RING;
        used      = 0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check_val({tag, ".clk_add_hour"},   clk_add_hour,   e_ch);
    check_val({tag, ".clk_add_minute"}, clk_add_minute, e_cm);
    check_val({tag, ".alm_add_hour"},   alm_add_hour,   e_ah);
    check_val({tag, ".alm_add_minute"}, alm_add_minute, e_am);
    check_val({tag, ".show_alarm"},     show_alarm,     editing);
    check_val({tag, ".ringing"},        ringing,        ring_left > 0);
    check_val({tag, ".snoozing"},       snoozing,       snz_left > 0);
    check_val({tag, ".snooze_left"},    snooze_left,    snz_left);
    check_val({tag, ".state_dbg"},      state_dbg,      mode_code());
  endtask

  // Called at a negedge: one active edge, model update, then sampling.
  task automatic run_cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    compare_all(tag);
    @(negedge clk);
  endtask

  task automatic drive_random();
    add_hour_pulse   = !add_hour_pulse && ($urandom_range(0, 11) == 0);
    add_minute_pulse = !add_minute_pulse && ($urandom_range(0, 7) == 0);
    if ($urandom_range(0, 4) == 0) clk_1s = ~clk_1s;
    if (set_alarm_sw) begin
      if ($urandom_range(0, 9) == 0) set_alarm_sw = 1'b0;
    end else if ($urandom_range(0, 79) == 0) begin
      set_alarm_sw = 1'b1;
    end
    if ($urandom_range(0, 199) == 0) alarm_en = ~alarm_en;
    if ($urandom_range(0, 3) == 0) begin
      case ($urandom_range(0, 3))
        0:       current_time = 24'h062959;
        1:       current_time = 24'h063000;
        2:       current_time = 24'h063001;
        default: current_time = 24'h070000;
      endcase
    end
  endtask

  initial begin
    resetN           = 1'b0;
    clk_1s           = 1'b0;
    add_hour_pulse   = 1'b0;
    add_minute_pulse = 1'b0;
    set_alarm_sw     = 1'b0;
    alarm_en         = 1'b1;
    alm_time         = 24'h063000;
    current_time     = 24'h120000;
    model_reset();
    #2;
    compare_all("reset");
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      drive_random();
      run_cycle("rand");
    end

    // Bring up a ring, then pull reset asynchronously mid-ring.
    add_hour_pulse   = 1'b0;
    add_minute_pulse = 1'b0;
    set_alarm_sw     = 1'b0;
    alarm_en         = 1'b1;
    current_time     = 24'h062959;
    for (int i = 0; i < 3; i++) run_cycle("pre_ring");
    current_time = 24'h063000;
    for (int i = 0; i < 10 && ring_left == 0; i++) run_cycle("to_ring");
    check_val("ring_reached", ringing, 1'b1);
    #2;
    resetN = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    check_val("async_rst.ringing_low", ringing, 1'b0);
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
    for (int i = 0; i < 20; i++) run_cycle("post_rst_hold");
    check_val("post_rst_no_ring", ringing, 1'b0);
    current_time = 24'h062959;
    for (int i = 0; i < 3; i++) run_cycle("post_rst_pre");
    current_time = 24'h063000;
    for (int i = 0; i < 4; i++) run_cycle("post_rst_ring");
    check_val("post_rst_rings_again", ringing, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl_fsm.md
Name: alarm_ctrl_fsm

Overview:
Mode and alarm controller for the clock-with-alarm design. It takes the debounced hour/minute pulses and the set-alarm switch, and routes the pulses either to the main time counter or to the alarm register. It detects the alarm match and sequences ringing, snooze and dismiss. It sits between the button debouncers/1 Hz divider and the time_mem/alarm_module datapath.

Parameters:
RING_TIMEOUT_S, 60, seconds of ringing before auto-dismiss (>=1)
SNOOZE_S, 300, snooze length in seconds (>=1)
MAX_SNOOZES, 3, snoozes allowed per alarm event; the next minute press dismisses
CNT_W, 16, width of the seconds down-counter; must hold max(RING_TIMEOUT_S, SNOOZE_S)

Ports:
clk  in  1  system clock, 100 MHz
resetN  in  1  asynchronous active-low reset
clk_1s  in  1  1 Hz level from the divider; rising edge = one second tick
add_hour_pulse  in  1  debounced one-cycle pulse (BTNL)
add_minute_pulse  in  1  debounced one-cycle pulse (BTNR)
set_alarm_sw  in  1  SW1 level; 1 = edit alarm
alarm_en  in  1  1 = alarm armed
current_time  in  24  BCD {HH,MM,SS}, 24 h format
alm_time  in  24  BCD {HH,MM,SS} alarm setting (SS ignored)
clk_add_hour  out  1  pulse to time_mem hour increment
clk_add_minute  out  1  pulse to time_mem minute increment
alm_add_hour  out  1  pulse to alarm hour increment
alm_add_minute  out  1  pulse to alarm minute increment
show_alarm  out  1  display mux select; 1 = alarm time
ringing  out  1  enables LED alarm sequence
snoozing  out  1  snooze active
snooze_left  out  CNT_W  remaining snooze seconds, binary; 0 outside SNOOZE
state_dbg  out  2  encoded FSM state

Behaviour:
- Reset (resetN=0, async): state IDLE; all outputs 0; counters 0; snooze count 0; tick-edge register 0; match-edge register 1, so a match already true at reset never rings.
- tick = clk_1s rising edge, registered; it is valid in the cycle after the edge.
- match = alarm_en && HH,MM equal && current SS==8'h00. The FSM acts on a match rising edge only, so one event per minute.
- All outputs are registered. Routed pulses appear one cycle after the input pulse and are exactly one cycle wide.
- IDLE (0): forward add_hour/add_minute to clk_add_*. Simultaneous pulses are both forwarded.
  - set_alarm_sw=1 -> SET_ALARM.
  - Otherwise a match edge -> RINGING: load counter with RING_TIMEOUT_S, clear snooze count.
- SET_ALARM (1): forward pulses to alm_add_*; show_alarm=1; match edges are ignored.
  - set_alarm_sw=0 -> IDLE.
- RINGING (2): ringing=1; pulses are not forwarded.
  - Priority, highest first: set_alarm_sw=1 -> SET_ALARM (dismiss); add_hour_pulse -> IDLE (dismiss); add_minute_pulse -> SNOOZE, or IDLE if snooze count==MAX_SNOOZES; tick with counter==1 -> IDLE (timeout); tick otherwise -> decrement.
  - Entering SNOOZE loads the counter with SNOOZE_S and increments the snooze count.
- SNOOZE (3): snoozing=1; snooze_left=counter.
  - Priority: set_alarm_sw=1 -> SET_ALARM; add_hour_pulse -> IDLE (cancel); tick with counter==1 -> RINGING (reload RING_TIMEOUT_S); tick otherwise -> decrement.
  - add_minute_pulse is ignored.
- Ringing lasts exactly RING_TIMEOUT_S ticks and snooze exactly SNOOZE_S ticks.
- A button press and a tick in the same cycle: the button wins and the tick is discarded.
- Leaving RINGING/SNOOZE to IDLE or SET_ALARM clears counter and snooze count.
- The counter never underflows; it is only decremented when >1.

Decomposition:
- alarm_ctrl_pkg: state enum (IDLE=2'd0, SET_ALARM=2'd1, RINGING=2'd2, SNOOZE=2'd3); BCD field slice localparams (HH=[23:16], MM=[15:8], SS=[7:0]).
- Sub-module rise_detect (parameter RESET_VAL), instanced twice: once for clk_1s, once for match.

Test Plan:
Bench parameters: RING_TIMEOUT_S=4, SNOOZE_S=3, MAX_SNOOZES=2.
- Routing: in IDLE pulse add_minute -> clk_add_minute=1 one cycle later, alm_add_minute stays 0. Set set_alarm_sw=1, pulse add_hour -> alm_add_hour=1, show_alarm=1, clk_add_hour stays 0.
- Match/timeout: alarm_en=1, alm_time=24'h063000, current_time steps 24'h062959 -> 24'h063000 -> ringing=1. After 4 ticks -> ringing=0, state IDLE; current_time held at 063000 does not re-ring.
- Snooze: while ringing, pulse add_minute -> snoozing=1, snooze_left=3,2,1. The 3rd tick -> ringing=1 again.
- Snooze limit: two snoozes, then a 3rd add_minute in RINGING -> IDLE. Add_hour pulse in RINGING -> immediate IDLE.
- Simultaneous events: a tick coinciding with add_minute at counter==1 in RINGING -> SNOOZE, not timeout. set_alarm_sw=1 arriving with a match edge in IDLE -> SET_ALARM, ringing=0.
- Reset mid-ring: drop resetN asynchronously -> all outputs 0 before the next clk edge. Release with a match already true -> no ring until the next match edge.
